// File: rtl/lenet_argmax.sv
// lenet_argmax: classification read-out stage.
// Scans NUM_CLASSES signed FC2 logits from the activation SRAM (read-only
// port) and reports the index and value of the largest one. Ties keep the
// lowest index because a later logit must be strictly greater to win.
module lenet_argmax #(
    parameter int BASE_ADDR   = 743,
    parameter int NUM_CLASSES = 10,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic [IDX_W-1:0]  class_id,
    output logic [DATA_W-1:0] class_score,
    output logic [3:0]        sram_act_wea,
    output logic [ADDR_W-1:0] sram_act_addr,
    input  logic [DATA_W-1:0] sram_act_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // One extra bit so the issue counter can hold NUM_CLASSES itself.
    localparam int CNT_W = IDX_W + 1;

    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CLASSES - 1);

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  issue_cnt_r;

    // Stage 1: an address was issued on the last edge, with its class index.
    logic              rd_vld_r;
    logic [IDX_W-1:0]  rd_idx_r;

    // Stage 2: sram_act_rdata currently holds the logit with this index.
    logic              tag_vld_r;
    logic [IDX_W-1:0]  tag_idx_r;

    // Running maximum; max_has_r low means "empty".
    logic              max_has_r;
    logic [DATA_W-1:0] max_val_r;
    logic [IDX_W-1:0]  max_idx_r;

    logic              start_acc_s;
    logic              last_issue_s;
    logic              final_cmp_s;
    logic              take_s;
    logic [DATA_W-1:0] nxt_val_s;
    logic [IDX_W-1:0]  nxt_idx_s;

    // The activation SRAM is only ever read here.
    assign sram_act_wea = 4'b0000;

    // Control decodes and the next running-max value for the live datum.
    always_comb begin
        start_acc_s  = (state_r == ST_IDLE) && start;
        last_issue_s = (state_r == ST_READ) && (issue_cnt_r == LAST_CNT);
        final_cmp_s  = (state_r == ST_DRAIN) && tag_vld_r && (tag_idx_r == LAST_IDX);
        if (tag_vld_r) begin
            take_s = (!max_has_r) || ($signed(sram_act_rdata) > $signed(max_val_r));
        end else begin
            take_s = 1'b0;
        end
        if (take_s) begin
            nxt_val_s = sram_act_rdata;
            nxt_idx_s = tag_idx_r;
        end else begin
            nxt_val_s = max_val_r;
            nxt_idx_s = max_idx_r;
        end
    end

    // Scan FSM: address issue, issue counter and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            issue_cnt_r   <= {CNT_W{1'b0}};
            sram_act_addr <= BASE_A;
            rd_vld_r      <= 1'b0;
            rd_idx_r      <= {IDX_W{1'b0}};
            busy          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_acc_s) begin
                        state_r       <= ST_READ;
                        sram_act_addr <= BASE_A;
                        issue_cnt_r   <= CNT_W'(1);
                        rd_vld_r      <= 1'b1;
                        rd_idx_r      <= {IDX_W{1'b0}};
                        busy          <= 1'b1;
                    end else begin
                        rd_vld_r      <= 1'b0;
                    end
                end
                ST_READ: begin
                    sram_act_addr <= sram_act_addr + ADDR_W'(1);
                    rd_idx_r      <= issue_cnt_r[IDX_W-1:0];
                    issue_cnt_r   <= issue_cnt_r + CNT_W'(1);
                    rd_vld_r      <= 1'b1;
                    if (last_issue_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_READ;
                    end
                end
                ST_DRAIN: begin
                    rd_vld_r <= 1'b0;
                    if (final_cmp_s) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    rd_vld_r <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Delay the issue tag by the one-cycle SRAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_r <= 1'b0;
            tag_idx_r <= {IDX_W{1'b0}};
        end else begin
            tag_vld_r <= rd_vld_r;
            tag_idx_r <= rd_idx_r;
        end
    end

    // Running maximum: cleared on start, updated on every live datum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_has_r <= 1'b0;
            max_val_r <= {DATA_W{1'b0}};
            max_idx_r <= {IDX_W{1'b0}};
        end else if (start_acc_s) begin
            max_has_r <= 1'b0;
            max_val_r <= {DATA_W{1'b0}};
            max_idx_r <= {IDX_W{1'b0}};
        end else if (tag_vld_r) begin
            max_has_r <= 1'b1;
            max_val_r <= nxt_val_s;
            max_idx_r <= nxt_idx_s;
        end else begin
            max_has_r <= max_has_r;
        end
    end

    // Result registers: loaded on the final compare edge, held while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done         <= 1'b0;
            result_valid <= 1'b0;
            class_id     <= {IDX_W{1'b0}};
            class_score  <= {DATA_W{1'b0}};
        end else begin
            done <= final_cmp_s;
            if (start_acc_s) begin
                result_valid <= 1'b0;
            end else if (final_cmp_s) begin
                result_valid <= 1'b1;
                class_id     <= nxt_idx_s;
                class_score  <= nxt_val_s;
            end else begin
                result_valid <= result_valid;
            end
        end
    end

endmodule

// File: tb/tb_lenet_argmax.sv
// Directed, table-driven bench for lenet_argmax with a 1-cycle SRAM model.
module tb_lenet_argmax;

    localparam int BASE = 743;
    localparam int NC   = 10;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic [3:0]  class_id;
    logic [31:0] class_score;
    logic [3:0]  sram_act_wea;
    logic [15:0] sram_act_addr;
    logic [31:0] sram_act_rdata;

    logic [9:0][31:0] mem;

    int n_chk;
    int n_fail;

    typedef struct {
        string            name;
        logic [9:0][31:0] lg;
        logic [3:0]       id;
        logic [31:0]      score;
    } vec_t;

    vec_t vecs [4];

    lenet_argmax dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .result_valid   (result_valid),
        .class_id       (class_id),
        .class_score    (class_score),
        .sram_act_wea   (sram_act_wea),
        .sram_act_addr  (sram_act_addr),
        .sram_act_rdata (sram_act_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: address captured on the edge, data valid after it.
    always @(posedge clk) begin
        int off;
        off = int'(sram_act_addr) - BASE;
        if (off >= 0 && off < NC) sram_act_rdata <= mem[off];
        else                      sram_act_rdata <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_rv"},    32'(result_valid), 32'd0);
        chk({tag, "_id"},    32'(class_id), 32'd0);
        chk({tag, "_score"}, class_score, 32'd0);
        chk({tag, "_addr"},  32'(sram_act_addr), 32'(BASE));
        chk({tag, "_wea"},   32'(sram_act_wea), 32'd0);
    endtask

    // Full scan starting #1 after an edge; ends #1 after the edge following done.
    task automatic do_scan(input string tag, input logic [3:0] eid, input logic [31:0] escore);
        int early;
        early = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_addr0"}, 32'(sram_act_addr), 32'(BASE));
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        chk({tag, "_rv0"},   32'(result_valid), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k < NC) chk({tag, "_addr"}, 32'(sram_act_addr), 32'(BASE + k));
            else        chk({tag, "_addr_hold"}, 32'(sram_act_addr), 32'(BASE + NC - 1));
            if (done) early++;
        end
        chk({tag, "_early_done"}, 32'(early), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done"},  32'(done), 32'd1);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_rv"},    32'(result_valid), 32'd1);
        chk({tag, "_id"},    32'(eid), 32'(class_id));
        chk({tag, "_score"}, class_score, escore);
        @(posedge clk); #1;
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_rv_hold"},  32'(result_valid), 32'd1);
        chk({tag, "_id_hold"},  32'(class_id), 32'(eid));
    endtask

    initial begin
        int cnt;
        n_chk  = 0;
        n_fail = 0;
        start  = 1'b0;
        rst    = 1'b1;
        mem    = '0;

        vecs[0].name = "main";
        vecs[0].lg   = {32'd1, 32'd41, -32'sd7, 32'd42, 32'd9, 32'd0, 32'd3, 32'd17, -32'sd2, 32'd5};
        vecs[0].id   = 4'd6;
        vecs[0].score = 32'd42;
        vecs[1].name = "allneg";
        for (int i = 0; i < NC; i++) vecs[1].lg[i] = 32'(-(12 - i));
        vecs[1].id    = 4'd9;
        vecs[1].score = 32'hFFFF_FFFD;
        vecs[2].name = "tie";
        for (int i = 0; i < NC; i++) vecs[2].lg[i] = 32'(i * 3);
        vecs[2].lg[2] = 32'd100;
        vecs[2].lg[7] = 32'd100;
        vecs[2].id    = 4'd2;
        vecs[2].score = 32'd100;
        vecs[3].name = "extremes";
        vecs[3].lg    = '0;
        vecs[3].lg[0] = 32'h8000_0000;
        vecs[3].lg[1] = 32'h7FFF_FFFF;
        vecs[3].id    = 4'd1;
        vecs[3].score = 32'h7FFF_FFFF;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("idle");

        // Table-driven scans.
        for (int v = 0; v < 4; v++) begin
            mem = vecs[v].lg;
            do_scan(vecs[v].name, vecs[v].id, vecs[v].score);
            @(posedge clk); #1;
        end

        // Restart attempt mid-scan plus start in the done cycle.
        mem = vecs[0].lg;
        start = 1'b1;
        @(posedge clk); #1;        // E0
        start = 1'b0;
        @(posedge clk); #1;        // E1
        @(posedge clk); #1;        // E2
        start = 1'b1;
        @(posedge clk); #1;        // E3 (ignored)
        start = 1'b0;
        chk("repulse_addr3", 32'(sram_act_addr), 32'(BASE + 3));
        cnt = 0;
        for (int k = 4; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("repulse_early_done", 32'(cnt), 32'd0);
        @(posedge clk); #1;        // E11
        chk("repulse_done", 32'(done), 32'd1);
        chk("repulse_id", 32'(class_id), 32'd6);
        chk("repulse_score", class_score, 32'd42);
        mem = vecs[1].lg;
        start = 1'b1;              // sampled at E12, in the done cycle
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_rv", 32'(result_valid), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_addr", 32'(sram_act_addr), 32'(BASE));
        chk("restart_id_hold", 32'(class_id), 32'd6);
        cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("restart_early_done", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        chk("restart_done2", 32'(done), 32'd1);
        chk("restart_id", 32'(class_id), 32'd9);
        chk("restart_score", class_score, 32'hFFFF_FFFD);
        @(posedge clk); #1;

        // Reset mid-scan, asserted ahead of E5.
        mem = vecs[3].lg;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done || busy) cnt++;
        end
        chk("midrst_no_done", 32'(cnt), 32'd0);
        chk("midrst_rv", 32'(result_valid), 32'd0);
        do_scan("postrst", 4'd1, 32'h7FFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
